// File: rtl/hls_core_staller_mc_if.sv
// Channel-side bundle for the multi-channel core staller: completions, masks,
// hang threshold and the stall/debug outputs handed back to the core.
interface hls_core_staller_mc_if #(
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 1,
    parameter int CNT_W   = 16,
    parameter int RUN_W   = 8,
    parameter int SRC_W   = ((NUM_IN + NUM_OUT) > 1) ? $clog2(NUM_IN + NUM_OUT) : 1
);
    logic [NUM_IN-1:0]  chn_in_wen_comp;
    logic [NUM_OUT-1:0] chn_out_wen_comp;
    logic [NUM_IN-1:0]  chn_in_mask;
    logic [NUM_OUT-1:0] chn_out_mask;
    logic [RUN_W-1:0]   timeout_thresh;
    logic               stat_clr;
    logic               core_wen;
    logic               core_wten;
    logic [CNT_W-1:0]   stall_cnt;
    logic [RUN_W-1:0]   stall_run;
    logic [1:0]         stall_state;
    logic [SRC_W-1:0]   stall_src;
    logic               stall_timeout;

    modport master (
        output chn_in_wen_comp, chn_out_wen_comp, chn_in_mask, chn_out_mask,
               timeout_thresh, stat_clr,
        input  core_wen, core_wten, stall_cnt, stall_run, stall_state,
               stall_src, stall_timeout
    );

    modport slave (
        input  chn_in_wen_comp, chn_out_wen_comp, chn_in_mask, chn_out_mask,
               timeout_thresh, stat_clr,
        output core_wen, core_wten, stall_cnt, stall_run, stall_state,
               stall_src, stall_timeout
    );
endinterface

// File: rtl/hls_core_staller_mc.sv
// Multi-channel core staller: merges channel completions into core_wen and keeps
// stall statistics, a RUN/STALL/HUNG hang detector and first-blocker capture.
module hls_core_staller_mc #(
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 1,
    parameter int CNT_W   = 16,
    parameter int RUN_W   = 8
) (
    input logic                 nvdla_core_clk,
    input logic                 nvdla_core_rstn,
    hls_core_staller_mc_if.slave bus
);
    localparam int NUM_CH = NUM_IN + NUM_OUT;
    localparam int SRC_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HUNG  = 2'd2,
        ST_ILL   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic               tout_q, tout_d;
    logic               wten_q;

    logic [NUM_CH-1:0]  ready_s;
    logic               core_wen_s;
    logic [SRC_W-1:0]   first_blk_s;
    logic [RUN_W:0]     run_inc_s;
    logic               hang_hit_s;

    // Outputs occupy indices NUM_IN.. above the inputs, matching stall_src numbering.
    assign ready_s    = {bus.chn_out_wen_comp | bus.chn_out_mask,
                         bus.chn_in_wen_comp  | bus.chn_in_mask};
    assign core_wen_s = &ready_s;
    assign run_inc_s  = {1'b0, run_q} + {{RUN_W{1'b0}}, 1'b1};
    assign hang_hit_s = (bus.timeout_thresh != {RUN_W{1'b0}}) &&
                        (run_inc_s >= {1'b0, bus.timeout_thresh});

    // Lowest-index non-ready channel; scanning downward lets lower indices win.
    always_comb begin
        first_blk_s = {SRC_W{1'b0}};
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            first_blk_s = ready_s[k] ? first_blk_s : SRC_W'(k);
        end
    end

    // Next-state logic for the hang detector and all statistics registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        src_d   = src_q;
        tout_d  = tout_q;

        case (state_q)
            ST_RUN: begin
                if (!core_wen_s) begin
                    state_d = ST_STALL;
                    src_d   = first_blk_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STALL: begin
                if (core_wen_s) begin
                    state_d = ST_RUN;
                end else if (hang_hit_s) begin
                    state_d = ST_HUNG;
                end else begin
                    state_d = ST_STALL;
                end
            end
            ST_HUNG: begin
                if (core_wen_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HUNG;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (bus.stat_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (!core_wen_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end

        if (core_wen_s) begin
            run_d = {RUN_W{1'b0}};
        end else if (run_q != {RUN_W{1'b1}}) begin
            run_d = run_inc_s[RUN_W-1:0];
        end else begin
            run_d = run_q;
        end

        // A hang entry in the same cycle as a clear still leaves the flag set.
        if ((state_q == ST_STALL) && (state_d == ST_HUNG)) begin
            tout_d = 1'b1;
        end else if (bus.stat_clr) begin
            tout_d = 1'b0;
        end else begin
            tout_d = tout_q;
        end
    end

    // State and statistics registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= ST_RUN;
            cnt_q   <= {CNT_W{1'b0}};
            run_q   <= {RUN_W{1'b0}};
            src_q   <= {SRC_W{1'b0}};
            tout_q  <= 1'b0;
            wten_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            src_q   <= src_d;
            tout_q  <= tout_d;
            wten_q  <= ~core_wen_s;
        end
    end

    assign bus.core_wen      = core_wen_s;
    assign bus.core_wten     = wten_q;
    assign bus.stall_cnt     = cnt_q;
    assign bus.stall_run     = run_q;
    assign bus.stall_state   = state_q;
    assign bus.stall_src     = src_q;
    assign bus.stall_timeout = tout_q;
endmodule

// File: tb/tb_hls_core_staller_mc.sv
// Self-checking bench for hls_core_staller_mc (NUM_IN=2, NUM_OUT=1, CNT_W=4).
module tb_hls_core_staller_mc;
    logic clk;
    logic rst_n;

    hls_core_staller_mc_if #(.NUM_IN(2), .NUM_OUT(1), .CNT_W(4), .RUN_W(8)) bus ();

    hls_core_staller_mc #(.NUM_IN(2), .NUM_OUT(1), .CNT_W(4), .RUN_W(8)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ic;
        logic       oc;
        logic [1:0] im;
        logic       om;
        logic [7:0] thr;
        logic       clr;
        logic       wen;
        logic       wten;
        logic [3:0] cnt;
        logic [7:0] run;
        logic [1:0] st;
        logic [1:0] src;
        logic       tout;
    } vec_t;

    typedef struct {
        string      tag;
        logic       wten;
        logic [3:0] cnt;
        logic [7:0] run;
        logic [1:0] st;
        logic [1:0] src;
        logic       tout;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] ic, input logic oc, input logic [1:0] im,
                                input logic om, input logic [7:0] thr, input logic clr,
                                input logic wen, input logic wten, input logic [3:0] cnt,
                                input logic [7:0] run, input logic [1:0] st,
                                input logic [1:0] src, input logic tout);
        vec_t v;
        v.ic = ic; v.oc = oc; v.im = im; v.om = om; v.thr = thr; v.clr = clr;
        v.wen = wen; v.wten = wten; v.cnt = cnt; v.run = run; v.st = st;
        v.src = src; v.tout = tout;
        return v;
    endfunction

    task automatic drive(input logic [1:0] ic, input logic oc, input logic [1:0] im,
                         input logic om, input logic [7:0] thr, input logic clr);
        bus.chn_in_wen_comp  = ic;
        bus.chn_out_wen_comp = oc;
        bus.chn_in_mask      = im;
        bus.chn_out_mask     = om;
        bus.timeout_thresh   = thr;
        bus.stat_clr         = clr;
    endtask

    // Called 1 time unit after a rising edge; leaves time aligned the same way.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        drive(v.ic, v.oc, v.im, v.om, v.thr, v.clr);
        #2;
        chk($sformatf("%s_core_wen", tag), bus.core_wen, v.wen);
        e.tag = tag; e.wten = v.wten; e.cnt = v.cnt; e.run = v.run;
        e.st = v.st; e.src = v.src; e.tout = v.tout;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk($sformatf("%s_scoreboard_empty", tag), 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s_core_wten", e.tag), bus.core_wten, e.wten);
            chk($sformatf("%s_stall_cnt", e.tag), bus.stall_cnt, e.cnt);
            chk($sformatf("%s_stall_run", e.tag), bus.stall_run, e.run);
            chk($sformatf("%s_stall_state", e.tag), bus.stall_state, e.st);
            chk($sformatf("%s_stall_src", e.tag), bus.stall_src, e.src);
            chk($sformatf("%s_stall_timeout", e.tag), bus.stall_timeout, e.tout);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;

        // Columns: in_comp, out_comp, in_mask, out_mask, thresh, clr | wen, wten, cnt, run, state, src, timeout
        vecs.push_back(mk(2'b11, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd1, 8'd1, 2'd1, 2'd2, 1'b0));
        vecs.push_back(mk(2'b11, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd2, 8'd2, 2'd1, 2'd2, 1'b0));
        vecs.push_back(mk(2'b11, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd3, 8'd3, 2'd1, 2'd2, 1'b0));
        vecs.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd3, 8'd0, 2'd0, 2'd2, 1'b0));
        vecs.push_back(mk(2'b00, 1'b1, 2'b01, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd4, 8'd1, 2'd1, 2'd1, 1'b0));
        vecs.push_back(mk(2'b00, 1'b1, 2'b11, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd4, 8'd0, 2'd0, 2'd1, 1'b0));
        vecs.push_back(mk(2'b00, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd5, 8'd1, 2'd1, 2'd0, 1'b0));
        vecs.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd5, 8'd0, 2'd0, 2'd0, 1'b0));
        vecs.push_back(mk(2'b11, 1'b0, 2'b00, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 4'd5, 8'd0, 2'd0, 2'd0, 1'b0));
        for (int k = 1; k <= 10; k++) begin
            vecs.push_back(mk(2'b01, 1'b1, 2'b00, 1'b0, 8'd5, 1'b0, 1'b0, 1'b1,
                              ((5 + k) > 15) ? 4'd15 : 4'(5 + k), 8'(k),
                              (k < 5) ? 2'd1 : 2'd2, 2'd1, (k >= 5) ? 1'b1 : 1'b0));
        end
        vecs.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0, 4'd15, 8'd0, 2'd0, 2'd1, 1'b1));
        vecs.push_back(mk(2'b01, 1'b1, 2'b00, 1'b0, 8'd5, 1'b0, 1'b0, 1'b1, 4'd15, 8'd1, 2'd1, 2'd1, 1'b1));
        vecs.push_back(mk(2'b01, 1'b1, 2'b00, 1'b0, 8'd5, 1'b1, 1'b0, 1'b1, 4'd0, 8'd2, 2'd1, 2'd1, 1'b0));
        vecs.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 2'd0, 2'd1, 1'b0));
        vecs.push_back(mk(2'b10, 1'b1, 2'b00, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 4'd1, 8'd1, 2'd1, 2'd0, 1'b0));
        vecs.push_back(mk(2'b10, 1'b1, 2'b00, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1, 4'd0, 8'd2, 2'd2, 2'd0, 1'b1));
        vecs.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 2'd0, 2'd0, 1'b1));
        vecs.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 2'd0, 2'd0, 1'b0));
        vecs.push_back(mk(2'b01, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd1, 8'd1, 2'd1, 2'd1, 1'b0));
        vecs.push_back(mk(2'b01, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd2, 8'd2, 2'd1, 2'd1, 1'b0));
        vecs.push_back(mk(2'b01, 1'b1, 2'b00, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 4'd3, 8'd3, 2'd2, 2'd1, 1'b1));
        vecs.push_back(mk(2'b11, 1'b1, 2'b00, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, 4'd3, 8'd0, 2'd0, 2'd1, 1'b1));

        // Reset with all channels ready.
        rst_n = 1'b0;
        drive(2'b11, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0);
        #1;
        chk("rst_core_wen", bus.core_wen, 1'b1);
        chk("rst_core_wten", bus.core_wten, 1'b0);
        chk("rst_stall_state", bus.stall_state, 2'd0);
        chk("rst_stall_cnt", bus.stall_cnt, 4'd0);
        chk("rst_stall_src", bus.stall_src, 2'd0);
        chk("rst_stall_timeout", bus.stall_timeout, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply(mk(2'b11, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 2'd0, 2'd0, 1'b0),
                  $sformatf("idle%0d", i));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Drive into HUNG with thresh=2, then assert reset mid-cycle.
        drive(2'b01, 1'b1, 2'b00, 1'b0, 8'd2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("hang_state_before_reset", bus.stall_state, 2'd2);
        chk("hang_run_before_reset", bus.stall_run, 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_core_wten", bus.core_wten, 1'b0);
        chk("async_rst_stall_cnt", bus.stall_cnt, 4'd0);
        chk("async_rst_stall_run", bus.stall_run, 8'd0);
        chk("async_rst_stall_state", bus.stall_state, 2'd0);
        chk("async_rst_stall_src", bus.stall_src, 2'd0);
        chk("async_rst_stall_timeout", bus.stall_timeout, 1'b0);
        chk("async_rst_core_wen_live", bus.core_wen, 1'b0);
        @(posedge clk);
        #1;
        chk("held_rst_stall_state", bus.stall_state, 2'd0);
        rst_n = 1'b1;
        apply(mk(2'b01, 1'b1, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd1, 8'd1, 2'd1, 2'd1, 1'b0),
              "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
